// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for a multicycle MIPS-style datapath. Walks each
//   instruction through FETCH -> DECODE -> EXEC [-> MEM] [-> WB]. Control
//   outputs are decoded from the current state and the latched opcode (op_q),
//   with two exceptions: FETCH/MEM handshakes react to mem_ready, and a beq in
//   EXEC drives pc_write from alu_zero.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   leaves IDLE; ignored in every other state
//   opcode[5:0]  in   instruction opcode field, latched in DECODE
//   mem_ready    in   memory access completes this cycle
//   alu_zero     in   ALU zero flag (beq)
//   alu_op[2:0]  out  000 add, 001 sub, 100 and, 101 or, 110 slt, 111 R-type
//   pc_write, ir_write, mem_read, mem_write, reg_write,
//   alu_src (1 = imm), reg_dst (1 = rd), mem_to_reg   out  datapath controls
//   halted       out  in HALT
//   err          out  sticky: an illegal opcode was decoded
//   instr_count  out  saturating count of fetched instructions
// -----------------------------------------------------------------------------
module multicycle_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic [2:0]  alu_op,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        halted,
  output logic        err,
  output logic [15:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_SUBI  = 6'b000011;
  localparam logic [5:0] OP_ANDI  = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b000101;
  localparam logic [5:0] OP_BEQ   = 6'b000110;
  localparam logic [5:0] OP_SLTI  = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_FUNC = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_IMM,
    C_LW,
    C_SW,
    C_BEQ,
    C_HALT,
    C_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [5:0] op);
    op_class_e c;
    case (op)
      OP_RTYPE:                                   c = C_RTYPE;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI: c = C_IMM;
      OP_LW:                                      c = C_LW;
      OP_SW:                                      c = C_SW;
      OP_BEQ:                                     c = C_BEQ;
      OP_HALT:                                    c = C_HALT;
      default:                                    c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] exec_alu_op(input logic [5:0] op);
    logic [2:0] a;
    case (op)
      OP_RTYPE:             a = ALU_FUNC;
      OP_ADDI, OP_LW, OP_SW: a = ALU_ADD;
      OP_SUBI, OP_BEQ:      a = ALU_SUB;
      OP_ANDI:              a = ALU_AND;
      OP_ORI:               a = ALU_OR;
      OP_SLTI:              a = ALU_SLT;
      default:              a = ALU_ADD;
    endcase
    return a;
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  op_class_e   cls_q;
  op_class_e   cls_in;

  assign cls_q  = classify(op_q);
  assign cls_in = classify(opcode);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    alu_op     = ALU_ADD;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
          state_d = S_DECODE;
        end
      end

      // The transition uses the live opcode because op_q only takes it at
      // the end of this cycle.
      S_DECODE: begin
        op_d = opcode;
        case (cls_in)
          C_HALT:    state_d = S_HALT;
          C_ILLEGAL: begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
          default:   state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        alu_op  = exec_alu_op(op_q);
        alu_src = (cls_q != C_RTYPE) && (cls_q != C_BEQ);
        case (cls_q)
          C_RTYPE, C_IMM: state_d = S_WB;
          C_LW, C_SW:     state_d = S_MEM;
          C_BEQ: begin
            pc_write = alu_zero;
            state_d  = S_FETCH;
          end
          default:        state_d = S_HALT;
        endcase
      end

      S_MEM: begin
        mem_read  = (cls_q == C_LW);
        mem_write = (cls_q == C_SW);
        if (mem_ready) state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
      end

      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls_q == C_RTYPE);
        mem_to_reg = (cls_q == C_LW);
        state_d    = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have these ports, clock and reset first: clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have reset_n, input, 1: asynchronous, active-low reset.
REQ-003 The block SHALL have start, input, 1: pulse that leaves IDLE.
REQ-004 The block SHALL have opcode, input, 6: opcode field of the instruction register, sampled in DECODE.
REQ-005 The block SHALL have mem_ready, input, 1: memory access completes this cycle.
REQ-006 The block SHALL have alu_zero, input, 1: ALU zero flag, used for beq.
REQ-007 The block SHALL have alu_op, output, 3: ALU operation to alu_control. Encoding: 000 add, 001 sub, 100 and, 101 or, 110 slt, 111 R-type (use function code).
REQ-008 The block SHALL have these 1-bit outputs: pc_write, ir_write, mem_read, mem_write, reg_write, alu_src (1 = immediate), reg_dst (1 = rd), mem_to_reg, halted, err.
REQ-009 The block SHALL have instr_count, output, 16: count of fetched instructions.

Function
REQ-010 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT; the state register updates on the rising clk edge.
REQ-011 Control outputs SHALL be Moore-decoded from the state and op_q; op_q is a 6-bit register loaded from opcode on the DECODE cycle.
REQ-012 Opcode table: 000000 R-type; 000010 addi; 000011 subi; 000100 andi; 000101 ori; 000111 slti; 100011 lw; 101011 sw; 000110 beq; 111111 halt; every other value is illegal.
REQ-013 IDLE: all control outputs 0; start=1 -> FETCH, otherwise the block stays in IDLE.
REQ-014 FETCH: mem_read=1; while mem_ready=0 the block stays in FETCH with ir_write=0 and pc_write=0.
REQ-015 FETCH with mem_ready=1: ir_write=1 and pc_write=1 (PC+4) in that cycle, instr_count increments, -> DECODE.
REQ-016 instr_count SHALL saturate at 16'hFFFF and not wrap.
REQ-017 DECODE: exactly 1 cycle with all control outputs 0; halt -> HALT; illegal opcode -> HALT with err=1; otherwise -> EXEC.
REQ-018 EXEC: exactly 1 cycle; alu_op = 111 for R-type; 000 for addi, lw and sw; 001 for subi and beq; 100 for andi; 101 for ori; 110 for slti.
REQ-019 EXEC: alu_src=1 for all immediate opcodes, lw and sw; alu_src=0 for R-type and beq.
REQ-020 EXEC transitions: lw/sw -> MEM; R-type and immediates -> WB; beq -> FETCH, with pc_write = alu_zero in that EXEC cycle.
REQ-021 MEM: lw drives mem_read=1, sw drives mem_write=1; the block holds in MEM until mem_ready=1, then lw -> WB and sw -> FETCH.
REQ-022 WB: exactly 1 cycle; reg_write=1, reg_dst=1 only for R-type, mem_to_reg=1 only for lw; -> FETCH.
REQ-023 HALT: halted=1 and all other control outputs 0; start is ignored; the block leaves HALT only on reset.
REQ-024 err SHALL be sticky until reset.
REQ-025 No more than one of mem_read and mem_write SHALL be 1 in any cycle.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 Cycle counts with mem_ready tied high: R-type/immediate 4 cycles, lw 5, sw 4, beq 3.

Reset
REQ-028 reset_n=0 SHALL immediately, without waiting for a clk edge, force state=IDLE, op_q=0, instr_count=0, err=0, halted=0 and all control outputs 0, including when reset is asserted mid-MEM or mid-FETCH.
REQ-029 After reset_n rises, the block SHALL stay in IDLE until start=1 is sampled on a rising clk edge.

Verification
REQ-030 Reset, then start; opcode=000000, mem_ready=1 -> per-cycle sequence FETCH(mem_read, ir_write, pc_write), DECODE, EXEC(alu_op=111, alu_src=0), WB(reg_write=1, reg_dst=1); instr_count=1.
REQ-031 lw with mem_ready low for 3 cycles in MEM -> mem_read held 4 cycles; WB has mem_to_reg=1 and reg_write=1; total 8 cycles from FETCH.
REQ-032 beq with alu_zero=1, then again with alu_zero=0 -> alu_op=001 in EXEC; pc_write=1 in EXEC in the first case only; next state FETCH in both cases.
REQ-033 Opcode 111110 -> HALT with err=1 and halted=1; a following start pulse -> no change.
REQ-034 reset_n dropped mid-MEM of sw -> mem_write goes to 0 asynchronously, before the next clk edge; all outputs read 0.
REQ-035 instr_count preloaded via 65535 fetches -> stays 16'hFFFF on the next fetch.
